// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation valve controller.
//  state_e  : controller FSM states
//  target_e : which main valve a PRIME phase is heading for
//  LVL_*    : water_box tank level encodings
//  max3     : constant helper for sizing the phase timer
package irrigation_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRIME    = 3'd1,
      RUN_SPR  = 3'd2,
      RUN_DRIP = 3'd3,
      FLUSH    = 3'd4,
      LOCKOUT  = 3'd5
   } state_e;

   typedef enum logic {
      SPR  = 1'b0,
      DRIP = 1'b1
   } target_e;

   localparam logic [1:0] LVL_EMPTY  = 2'b00;
   localparam logic [1:0] LVL_MEDIUM = 2'b10;
   localparam logic [1:0] LVL_FULL   = 2'b11;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV cycles.
//  clk  in  system clock
//  rst  in  synchronous active-high reset
//  clr  in  restart the count (tick then fires DIV cycles later)
//  tick out high for the last cycle of each DIV-cycle period
module tick_prescaler #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_r;

   assign tick = (cnt_r == CW'(DIV - 1));

   // Cycle counter, restarted on reset, clear or wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (tick) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/irrigation_valve_ctrl.sv
// Timed valve/pump sequencer: IDLE -> PRIME -> RUN_SPR/RUN_DRIP -> FLUSH,
// with an empty-tank LOCKOUT that overrides every other state.
// Optional feature macro: USAGE_COUNTER_EN (adds water_usage[15:0]).
//  clk, rst                      clock, synchronous active-high reset
//  sprinkler_req, drip_req       main valve requests (sprinkler has priority)
//  specific_req                  specific-treatment request (outside the FSM)
//  water_box[1:0]                tank level, 2'b00 = empty
//  sprinkler_valve, drip_valve   main valves (registered)
//  specific_valve, pump_on       specific valve, pump enable (registered)
//  busy, fault                   not IDLE, lockout active (registered)
//  water_usage[15:0]             ticks with a main valve open (optional)
module irrigation_valve_ctrl
   import irrigation_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int PRIME_T  = 2,
   parameter int MIN_ON   = 3,
   parameter int MAX_ON   = 8,
   parameter int COOLDOWN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sprinkler_req,
   input  logic       drip_req,
   input  logic       specific_req,
   input  logic [1:0] water_box,
   output logic       sprinkler_valve,
   output logic       drip_valve,
   output logic       specific_valve,
   output logic       pump_on,
   output logic       busy,
   output logic       fault
`ifdef USAGE_COUNTER_EN
   ,
   output logic [15:0] water_usage
`endif
);

   localparam int TW = $clog2(max3(PRIME_T, MAX_ON, COOLDOWN) + 1);
   localparam logic [TW-1:0] PRIME_LIM = TW'(PRIME_T);
   localparam logic [TW-1:0] MIN_LIM   = TW'(MIN_ON);
   localparam logic [TW-1:0] MAX_LIM   = TW'(MAX_ON);
   localparam logic [TW-1:0] COOL_LIM  = TW'(COOLDOWN);

   state_e        state_r, next_state_s, idle_state_s;
   target_e       target_r, next_target_s, idle_target_s;
   logic [TW-1:0] timer_r, elapsed_s;
   logic          tick_s, entry_s, empty_s, timed_s, target_req_s;
   logic          sprinkler_valve_r, drip_valve_r, specific_valve_r;
   logic          pump_on_r, busy_r, fault_r;

   assign empty_s      = (water_box == LVL_EMPTY);
   assign entry_s      = (next_state_s != state_r);
   assign timed_s      = (state_r == PRIME) || (state_r == RUN_SPR) ||
                         (state_r == RUN_DRIP) || (state_r == FLUSH);
   // Ticks completed in this state, counting a tick that lands this cycle.
   assign elapsed_s    = timer_r + TW'(tick_s);
   assign target_req_s = (target_r == SPR) ? sprinkler_req : drip_req;

   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (entry_s),
      .tick (tick_s)
   );

   // Request arbitration shared by IDLE and the end of FLUSH
   always_comb begin
      idle_state_s  = IDLE;
      idle_target_s = target_r;
      if (sprinkler_req) begin
         idle_state_s  = PRIME;
         idle_target_s = SPR;
      end else if (drip_req) begin
         idle_state_s  = PRIME;
         idle_target_s = DRIP;
      end else begin
         idle_state_s  = IDLE;
         idle_target_s = target_r;
      end
   end

   // Next-state logic; an empty tank overrides every state
   always_comb begin
      next_state_s  = state_r;
      next_target_s = target_r;
      if (empty_s) begin
         next_state_s = LOCKOUT;
      end else begin
         case (state_r)
            IDLE: begin
               next_state_s  = idle_state_s;
               next_target_s = idle_target_s;
            end
            PRIME: begin
               if (!target_req_s) begin
                  next_state_s = IDLE;
               end else if (elapsed_s == PRIME_LIM) begin
                  next_state_s = (target_r == SPR) ? RUN_SPR : RUN_DRIP;
               end else begin
                  next_state_s = PRIME;
               end
            end
            RUN_SPR: begin
               if ((elapsed_s == MAX_LIM) || (!sprinkler_req && (elapsed_s >= MIN_LIM))) begin
                  next_state_s = FLUSH;
               end else begin
                  next_state_s = RUN_SPR;
               end
            end
            RUN_DRIP: begin
               if ((elapsed_s == MAX_LIM) || (!drip_req && (elapsed_s >= MIN_LIM))) begin
                  next_state_s = FLUSH;
               end else begin
                  next_state_s = RUN_DRIP;
               end
            end
            FLUSH: begin
               // Cooldown expiry passes straight through IDLE's arbitration,
               // so a held request re-primes on the same edge.
               if (elapsed_s == COOL_LIM) begin
                  next_state_s  = idle_state_s;
                  next_target_s = idle_target_s;
               end else begin
                  next_state_s = FLUSH;
               end
            end
            LOCKOUT: begin
               next_state_s = FLUSH;
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   // State, phase timer and Moore outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= IDLE;
         target_r          <= SPR;
         timer_r           <= {TW{1'b0}};
         sprinkler_valve_r <= 1'b0;
         drip_valve_r      <= 1'b0;
         specific_valve_r  <= 1'b0;
         pump_on_r         <= 1'b0;
         busy_r            <= 1'b0;
         fault_r           <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         target_r <= next_target_s;
         if (entry_s) begin
            timer_r <= {TW{1'b0}};
         end else if (tick_s && timed_s) begin
            timer_r <= elapsed_s;
         end else begin
            timer_r <= timer_r;
         end
         sprinkler_valve_r <= (next_state_s == RUN_SPR);
         drip_valve_r      <= (next_state_s == RUN_DRIP);
         pump_on_r         <= (next_state_s == PRIME) || (next_state_s == RUN_SPR) ||
                              (next_state_s == RUN_DRIP);
         busy_r            <= (next_state_s != IDLE);
         fault_r           <= (next_state_s == LOCKOUT);
         specific_valve_r  <= specific_req && !empty_s && (state_r != LOCKOUT);
      end
   end

   assign sprinkler_valve = sprinkler_valve_r;
   assign drip_valve      = drip_valve_r;
   assign specific_valve  = specific_valve_r;
   assign pump_on         = pump_on_r;
   assign busy            = busy_r;
   assign fault           = fault_r;

`ifdef USAGE_COUNTER_EN
   logic [15:0] usage_r;

   // Saturating count of ticks spent with a main valve open
   always_ff @(posedge clk) begin
      if (rst) begin
         usage_r <= 16'h0000;
      end else if (tick_s && (sprinkler_valve_r || drip_valve_r) && (usage_r != 16'hFFFF)) begin
         usage_r <= usage_r + 16'h0001;
      end else begin
         usage_r <= usage_r;
      end
   end

   assign water_usage = usage_r;
`endif

endmodule

// File: tb/tb_irrigation_valve_ctrl.sv
// Self-checking bench for irrigation_valve_ctrl with a cycle-counting
// reference model plus hand-computed edge expectations.
module tb_irrigation_valve_ctrl;
   import irrigation_pkg::*;

   localparam int P_DIV  = 4;
   localparam int P_PRI  = 2;
   localparam int P_MIN  = 3;
   localparam int P_MAX  = 8;
   localparam int P_COOL = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sprinkler_req = 1'b0;
   logic       drip_req = 1'b0;
   logic       specific_req = 1'b0;
   logic [1:0] water_box = LVL_FULL;
   logic       sprinkler_valve, drip_valve, specific_valve, pump_on, busy, fault;
`ifdef USAGE_COUNTER_EN
   logic [15:0] water_usage;
`endif

   int tests  = 0;
   int failed = 0;
   int edge_cnt = 0;

   irrigation_valve_ctrl #(
      .TICK_DIV (P_DIV),
      .PRIME_T  (P_PRI),
      .MIN_ON   (P_MIN),
      .MAX_ON   (P_MAX),
      .COOLDOWN (P_COOL)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sprinkler_req   (sprinkler_req),
      .drip_req        (drip_req),
      .specific_req    (specific_req),
      .water_box       (water_box),
      .sprinkler_valve (sprinkler_valve),
      .drip_valve      (drip_valve),
      .specific_valve  (specific_valve),
      .pump_on         (pump_on),
      .busy            (busy),
      .fault           (fault)
`ifdef USAGE_COUNTER_EN
      ,
      .water_usage     (water_usage)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s at edge %0d t=%0t: got %b want %b", name, edge_cnt, $time, act, exp);
      end
   endtask

   // Reference model: phases measured in whole clock cycles since entry.
   localparam int PH_IDLE = 0, PH_PRIME = 1, PH_RSPR = 2, PH_RDRP = 3, PH_FLUSH = 4, PH_LOCK = 5;
   int   m_ph = PH_IDLE;
   int   m_cyc = 0;
   bit   m_to_spr = 1'b1;
   logic m_spr = 1'b0, m_drp = 1'b0, m_spec = 1'b0, m_pump = 1'b0, m_busy = 1'b0, m_fault = 1'b0;
   int   m_usage = 0;

   always @(posedge clk) begin
      int  n, nph;
      bit  req, nto;
      if (rst) begin
         m_ph = PH_IDLE; m_cyc = 0; m_usage = 0; edge_cnt = 0;
         m_spec = 1'b0;
      end else begin
         edge_cnt++;
         n   = m_cyc + 1;
         nph = m_ph;
         nto = m_to_spr;
         m_spec = specific_req && (water_box != 2'b00) && (m_ph != PH_LOCK);
         if ((m_ph == PH_RSPR || m_ph == PH_RDRP) && (n % P_DIV == 0) && m_usage < 65535)
            m_usage++;
         if (water_box == 2'b00) nph = PH_LOCK;
         else begin
            case (m_ph)
               PH_IDLE, PH_FLUSH: begin
                  if (m_ph == PH_IDLE || n == P_COOL * P_DIV) begin
                     if (sprinkler_req) begin nph = PH_PRIME; nto = 1'b1; end
                     else if (drip_req) begin nph = PH_PRIME; nto = 1'b0; end
                     else nph = PH_IDLE;
                  end
               end
               PH_PRIME: begin
                  req = m_to_spr ? sprinkler_req : drip_req;
                  if (!req) nph = PH_IDLE;
                  else if (n == P_PRI * P_DIV) nph = m_to_spr ? PH_RSPR : PH_RDRP;
               end
               PH_RSPR, PH_RDRP: begin
                  req = (m_ph == PH_RSPR) ? sprinkler_req : drip_req;
                  if (n == P_MAX * P_DIV || (!req && (n / P_DIV) >= P_MIN)) nph = PH_FLUSH;
               end
               default: nph = PH_FLUSH;
            endcase
         end
         m_cyc = (nph == m_ph) ? n : 0;
         m_ph = nph;
         m_to_spr = nto;
      end
      m_spr   = (m_ph == PH_RSPR);
      m_drp   = (m_ph == PH_RDRP);
      m_pump  = (m_ph == PH_PRIME || m_ph == PH_RSPR || m_ph == PH_RDRP);
      m_busy  = (m_ph != PH_IDLE);
      m_fault = (m_ph == PH_LOCK);
      #1;
      check("m_sprinkler_valve", sprinkler_valve, m_spr);
      check("m_drip_valve", drip_valve, m_drp);
      check("m_specific_valve", specific_valve, m_spec);
      check("m_pump_on", pump_on, m_pump);
      check("m_busy", busy, m_busy);
      check("m_fault", fault, m_fault);
`ifdef USAGE_COUNTER_EN
      tests++;
      if (water_usage !== 16'(m_usage)) begin
         failed++;
         $display("FAIL m_water_usage at edge %0d: got %0d want %0d", edge_cnt, water_usage, m_usage);
      end
`endif
   end

   task automatic wait_edge(input int n);
      int guard;
      guard = 0;
      while (edge_cnt < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      tests++;
      if (edge_cnt != n) begin
         failed++;
         $display("FAIL wait_edge: reached edge %0d want %0d", edge_cnt, n);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sprinkler_req = 1'b0; drip_req = 1'b0; specific_req = 1'b0;
      water_box = LVL_FULL;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("reset_busy", busy, 1'b0);
      check("reset_pump", pump_on, 1'b0);
      check("reset_fault", fault, 1'b0);

      // 1: sprinkler held, forced end at MAX_ON, re-prime after cooldown
      sprinkler_req = 1'b1;
      wait_edge(1);  check("s1_pump_e1", pump_on, 1'b1); check("s1_valve_e1", sprinkler_valve, 1'b0);
      wait_edge(8);  check("s1_valve_e8", sprinkler_valve, 1'b0);
      wait_edge(9);  check("s1_valve_e9", sprinkler_valve, 1'b1);
      wait_edge(40); check("s1_valve_e40", sprinkler_valve, 1'b1);
      wait_edge(41); check("s1_valve_e41", sprinkler_valve, 1'b0); check("s1_busy_e41", busy, 1'b1);
`ifdef USAGE_COUNTER_EN
      tests++;
      if (water_usage !== 16'd8) begin
         failed++;
         $display("FAIL s1_usage: got %0d want 8", water_usage);
      end
`endif
      wait_edge(48); check("s1_pump_e48", pump_on, 1'b0);
      wait_edge(49); check("s1_pump_e49", pump_on, 1'b1); check("s1_valve_e49", sprinkler_valve, 1'b0);
      sprinkler_req = 1'b0;
      wait_edge(55); check("s1_idle", busy, 1'b0);

      // 2: single-cycle drip pulse aborts PRIME
      do_reset();
      drip_req = 1'b1;
      wait_edge(1); check("s2_busy_e1", busy, 1'b1);
      drip_req = 1'b0;
      wait_edge(2); check("s2_busy_e2", busy, 1'b0);
      wait_edge(20); check("s2_drip_closed", drip_valve, 1'b0);

      // 3: drip dropped two ticks into RUN_DRIP, held open until MIN_ON
      do_reset();
      drip_req = 1'b1;
      wait_edge(9);  check("s3_drip_e9", drip_valve, 1'b1);
      wait_edge(17); drip_req = 1'b0;
      wait_edge(20); check("s3_drip_e20", drip_valve, 1'b1);
      wait_edge(21); check("s3_drip_e21", drip_valve, 1'b0); check("s3_busy_e21", busy, 1'b1);
      wait_edge(28); check("s3_busy_e28", busy, 1'b1);
      wait_edge(29); check("s3_busy_e29", busy, 1'b0);

      // 4: both requests, sprinkler first, drip after cooldown
      do_reset();
      sprinkler_req = 1'b1; drip_req = 1'b1;
      wait_edge(9);  check("s4_spr_e9", sprinkler_valve, 1'b1); check("s4_drp_e9", drip_valve, 1'b0);
      wait_edge(12); sprinkler_req = 1'b0;
      wait_edge(20); check("s4_spr_e20", sprinkler_valve, 1'b1);
      wait_edge(21); check("s4_spr_e21", sprinkler_valve, 1'b0);
      wait_edge(29); check("s4_pump_e29", pump_on, 1'b1);
      wait_edge(36); check("s4_drp_e36", drip_valve, 1'b0);
      wait_edge(37); check("s4_drp_e37", drip_valve, 1'b1); check("s4_spr_e37", sprinkler_valve, 1'b0);
      drip_req = 1'b0;
      wait_edge(50);

      // 5: empty tank mid-run, recovery, then reset mid-run
      do_reset();
      sprinkler_req = 1'b1; specific_req = 1'b1;
      wait_edge(1);  check("s5_spec_e1", specific_valve, 1'b1);
      wait_edge(12); water_box = LVL_EMPTY;
      wait_edge(13);
      check("s5_fault_e13", fault, 1'b1); check("s5_pump_e13", pump_on, 1'b0);
      check("s5_valve_e13", sprinkler_valve, 1'b0); check("s5_spec_e13", specific_valve, 1'b0);
      wait_edge(15); water_box = LVL_MEDIUM;
      wait_edge(16);
      check("s5_fault_e16", fault, 1'b0); check("s5_busy_e16", busy, 1'b1);
      check("s5_spec_e16", specific_valve, 1'b0);
      wait_edge(17); check("s5_spec_e17", specific_valve, 1'b1);
      wait_edge(24); check("s5_pump_e24", pump_on, 1'b1);
      wait_edge(32); check("s5_valve_e32", sprinkler_valve, 1'b1);
      wait_edge(34);
      rst = 1'b1;
      @(negedge clk);
      check("s5_rst_valve", sprinkler_valve, 1'b0); check("s5_rst_pump", pump_on, 1'b0);
      check("s5_rst_busy", busy, 1'b0); check("s5_rst_spec", specific_valve, 1'b0);
      rst = 1'b0; sprinkler_req = 1'b0; specific_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
